// File: rtl/fetch_pkg.sv
// Types and constants shared by the instruction fetch queue and its storage.
package fetch_pkg;

    // Entry fields are sized for the widest supported ADDR_W/DATA_W; narrower
    // instances use the low bits and leave the upper bits zero.
    localparam int unsigned MAX_ADDR_W = 64;
    localparam int unsigned MAX_DATA_W = 64;

    localparam logic [MAX_DATA_W-1:0] ZERO_WORD = '0;
    localparam int unsigned           PC_STEP   = 4;

    typedef struct packed {
        logic [MAX_ADDR_W-1:0] pc;
        logic [MAX_DATA_W-1:0] instr;
        logic                  fault;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer FIFO for fetched entries; flush empties it in a single cycle.
module fetch_fifo #(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Sequential instruction prefetcher feeding a DEPTH-entry queue, with redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN turns a misaligned redirect into a fault entry.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_fault
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    if (DEPTH < 2 || DEPTH > 16) begin : g_bad_depth
        $error("instr_fetch_queue: DEPTH must be in 2..16");
    end
    if (ADDR_W < 3 || ADDR_W > MAX_ADDR_W || DATA_W < 1 || DATA_W > MAX_DATA_W) begin : g_bad_w
        $error("instr_fetch_queue: ADDR_W/DATA_W out of supported range");
    end

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              halt_q;
    logic              fault_pend_q;
    logic [ADDR_W-1:0] target_pc;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              head_valid;
    logic              pop;
    logic              push;
    logic              issue;
    logic [OCC_W-1:0]  occupancy;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    assign head_valid = !fifo_empty && !reset;
    // Redirect wins over a same-cycle pop, push or issue.
    assign pop        = head_valid && out_ready && !redirect_valid;
    assign occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue      = !reset && !redirect_valid && !halt_q && (occupancy < OCC_W'(DEPTH));
    assign push       = !reset && !redirect_valid && (inflight_q || fault_pend_q);

    assign mem_req  = issue;
    assign mem_addr = {fetch_pc_q[ADDR_W-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic halt_d;
    logic fault_pend_d;
    logic target_misaligned;

    assign target_pc         = redirect_pc;
    assign target_misaligned = is_misaligned(redirect_pc[1:0]);

    // A misaligned target yields one fault entry, then fetch stalls until the next redirect.
    always_comb begin
        halt_d       = halt_q;
        fault_pend_d = 1'b0;
        if (redirect_valid) begin
            halt_d       = target_misaligned;
            fault_pend_d = target_misaligned;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            halt_q       <= 1'b0;
            fault_pend_q <= 1'b0;
        end else begin
            halt_q       <= halt_d;
            fault_pend_q <= fault_pend_d;
        end
    end

    assign out_fault = head_valid && head_entry.fault;
`else
    assign target_pc    = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign halt_q       = 1'b0;
    assign fault_pend_q = 1'b0;
    assign out_fault    = 1'b0;
`endif

    always_comb begin
        push_entry = '0;
        if (fault_pend_q) begin
            push_entry.pc[ADDR_W-1:0] = fetch_pc_q;
            push_entry.instr          = ZERO_WORD;
            push_entry.fault          = 1'b1;
        end else begin
            push_entry.pc[ADDR_W-1:0]    = inflight_pc_q;
            push_entry.instr[DATA_W-1:0] = mem_rdata;
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            inflight_d = 1'b0;
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_STEP);
            inflight_pc_d = mem_addr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign out_valid = head_valid;
    assign out_pc    = head_valid ? head_entry.pc[ADDR_W-1:0] : '0;
    assign out_instr = head_valid ? head_entry.instr[DATA_W-1:0] : ZERO_WORD[DATA_W-1:0];

    logic unused_bits;
    assign unused_bits = ^{head_entry, redirect_pc[1:0], fifo_full};

endmodule
